// File: rtl/decode_writeback.sv
// Y86-64 register file with decode (source select, operand read) and writeback
// (destination select, commit), plus sticky halt/invalid status and a retire counter.
module decode_writeback #(
  parameter logic [63:0] STACK_INIT = 64'h0000_0000_0000_0200,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_en,
  input  logic [3:0]       icode,
  input  logic [3:0]       rA,
  input  logic [3:0]       rB,
  input  logic             cond,
  input  logic [63:0]      valE,
  input  logic [63:0]      valM,
  output logic [63:0]      valA,
  output logic [63:0]      valB,
  output logic             halted,
  output logic             instr_err,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] REG_RSP  = 4'h4;

  typedef enum logic [3:0] {
    I_HALT   = 4'h0, I_NOP    = 4'h1, I_CMOV   = 4'h2, I_IRMOV  = 4'h3,
    I_RMMOV  = 4'h4, I_MRMOV  = 4'h5, I_OP     = 4'h6, I_JXX    = 4'h7,
    I_CALL   = 4'h8, I_RET    = 4'h9, I_PUSH   = 4'hA, I_POP    = 4'hB
  } icode_e;

  logic [63:0] regs [15];
  logic [3:0]  src_a, src_b, dst_e, dst_m;
  logic        commit;
  logic        bad_icode;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    src_a = REG_NONE;
    src_b = REG_NONE;
    dst_e = REG_NONE;
    dst_m = REG_NONE;
    case (icode)
      I_CMOV:  begin src_a = rA; dst_e = cond ? rB : REG_NONE; end
      I_IRMOV: dst_e = rB;
      I_RMMOV: begin src_a = rA; src_b = rB; end
      I_MRMOV: begin src_b = rB; dst_m = rA; end
      I_OP:    begin src_a = rA; src_b = rB; dst_e = rB; end
      I_CALL:  begin src_b = REG_RSP; dst_e = REG_RSP; end
      I_RET:   begin src_a = REG_RSP; src_b = REG_RSP; dst_e = REG_RSP; end
      I_PUSH:  begin src_a = rA; src_b = REG_RSP; dst_e = REG_RSP; end
      I_POP:   begin src_a = REG_RSP; src_b = REG_RSP; dst_e = REG_RSP; dst_m = rA; end
      default: ;
    endcase
  end

  // No bypass: reads see the pre-commit contents.
  assign valA = (src_a == REG_NONE) ? 64'd0 : regs[src_a];
  assign valB = (src_b == REG_NONE) ? 64'd0 : regs[src_b];

  assign bad_icode = (icode > I_POP);
  assign commit    = wb_en && !halted && !instr_err;

  // NOTE: the register array is reset element by element because %rsp has a non-zero reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) regs[i] <= (i == 4) ? STACK_INIT : 64'd0;
      halted    <= 1'b0;
      instr_err <= 1'b0;
      retired   <= '0;
    end else if (commit) begin
      if (bad_icode) begin
        instr_err <= 1'b1;
      end else begin
        // valM takes priority so popq %rsp leaves the popped value.
        for (int i = 0; i < 15; i++) begin
          if (dst_m == 4'(i))      regs[i] <= valM;
          else if (dst_e == 4'(i)) regs[i] <= valE;
        end
        if (icode == I_HALT) halted <= 1'b1;
        if (retired != '1) retired <= retired + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_decode_writeback.sv
// Self-checking bench for decode_writeback: directed plan followed by randomized
// instruction streams compared against an architectural model of the Y86-64 register file.
module tb_decode_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_en = 1'b0;
  logic [3:0]  icode = 4'h1;
  logic [3:0]  rA = 4'hF;
  logic [3:0]  rB = 4'hF;
  logic        cond = 1'b0;
  logic [63:0] valE = '0;
  logic [63:0] valM = '0;
  logic [63:0] valA, valB;
  logic        halted, instr_err;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  // Architectural model state
  logic [63:0] m_reg [15];
  logic        m_halted, m_err;
  logic [31:0] m_retired;

  decode_writeback dut (
    .clk(clk), .rst(rst), .wb_en(wb_en), .icode(icode), .rA(rA), .rB(rB),
    .cond(cond), .valE(valE), .valM(valM), .valA(valA), .valB(valB),
    .halted(halted), .instr_err(instr_err), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] m_read(input logic [3:0] r);
    return (r == 4'hF) ? 64'd0 : m_reg[r];
  endfunction

  // Operand A of each instruction class, from the ISA description.
  function automatic logic [63:0] exp_a(input logic [3:0] ic, input logic [3:0] a);
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return m_read(a);
    if (ic inside {4'h9, 4'hB})             return m_read(4'h4);
    return 64'd0;
  endfunction

  function automatic logic [63:0] exp_b(input logic [3:0] ic, input logic [3:0] b);
    if (ic inside {4'h4, 4'h5, 4'h6})       return m_read(b);
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return m_read(4'h4);
    return 64'd0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 15; i++) m_reg[i] = 64'd0;
    m_reg[4]  = 64'h200;
    m_halted  = 1'b0;
    m_err     = 1'b0;
    m_retired = 32'd0;
  endtask

  task automatic m_commit(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                          input logic c, input logic [63:0] e, input logic [63:0] m);
    if (m_halted || m_err) return;
    if (ic > 4'hB) begin
      m_err = 1'b1;
      return;
    end
    case (ic)
      4'h0: m_halted = 1'b1;
      4'h2: if (c && b != 4'hF) m_reg[b] = e;
      4'h3, 4'h6: if (b != 4'hF) m_reg[b] = e;
      4'h5: if (a != 4'hF) m_reg[a] = m;
      4'h8, 4'h9, 4'hA: m_reg[4] = e;
      4'hB: begin
        m_reg[4] = e;
        if (a != 4'hF) m_reg[a] = m;
      end
      default: ;
    endcase
    if (m_retired != 32'hFFFF_FFFF) m_retired = m_retired + 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    m_reset();
  endtask

  // Apply inputs without a clock edge (wb_en low) so operands can be inspected.
  task automatic read(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    wb_en = 1'b0; icode = ic; rA = a; rB = b; cond = 1'b0;
    #1;
  endtask

  task automatic step(input string tag, input logic w, input logic [3:0] ic,
                      input logic [3:0] a, input logic [3:0] b, input logic c,
                      input logic [63:0] e, input logic [63:0] m);
    @(negedge clk);
    wb_en = w; icode = ic; rA = a; rB = b; cond = c; valE = e; valM = m;
    #1;
    check({tag, "_valA"}, valA, exp_a(ic, a));
    check({tag, "_valB"}, valB, exp_b(ic, b));
    @(posedge clk);
    if (w) m_commit(ic, a, b, c, e, m);
    #1;
    check({tag, "_retired"}, {32'd0, retired}, {32'd0, m_retired});
    check({tag, "_halted"}, {63'd0, halted}, {63'd0, m_halted});
    check({tag, "_err"}, {63'd0, instr_err}, {63'd0, m_err});
    wb_en = 1'b0;
  endtask

  initial begin
    m_reset();
    rst = 1'b1;
    #12;
    rst = 1'b0;

    // 1. Reset state
    read(4'h9, 4'hF, 4'hF);
    check("rst_rsp_a", valA, 64'h200);
    check("rst_rsp_b", valB, 64'h200);
    read(4'h6, 4'h0, 4'h1);
    check("rst_r0", valA, 64'd0);
    check("rst_r1", valB, 64'd0);
    check("rst_retired", {32'd0, retired}, 64'd0);

    // 2. irmovq then OPq readback
    step("irmov", 1'b1, 4'h3, 4'hF, 4'h2, 1'b0, 64'h1122334455667788, 64'd0);
    read(4'h6, 4'h2, 4'h2);
    check("op_a", valA, 64'h1122334455667788);
    check("op_b", valB, 64'h1122334455667788);
    check("op_retired", {32'd0, retired}, 64'd1);

    // 3. cmovxx gating
    step("cmov0", 1'b1, 4'h2, 4'h0, 4'h3, 1'b0, 64'd5, 64'd0);
    read(4'h6, 4'h3, 4'hF);
    check("cmov0_r3", valA, 64'd0);
    step("cmov1", 1'b1, 4'h2, 4'h0, 4'h3, 1'b1, 64'd5, 64'd0);
    read(4'h6, 4'h3, 4'hF);
    check("cmov1_r3", valA, 64'd5);

    // 4. popq %rsp: valM wins
    step("poprsp", 1'b1, 4'hB, 4'h4, 4'hF, 1'b0, 64'h208, 64'hDEAD);
    read(4'h9, 4'hF, 4'hF);
    check("poprsp_a", valA, 64'hDEAD);

    // wb_en low changes nothing
    step("nowb", 1'b0, 4'h3, 4'hF, 4'h7, 1'b0, 64'h77, 64'd0);

    // 5. halt freezes state
    step("halt", 1'b1, 4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0);
    check("halt_flag", {63'd0, halted}, 64'd1);
    check("halt_retired", {32'd0, retired}, 64'd5);
    step("after_halt", 1'b1, 4'h3, 4'hF, 4'h5, 1'b0, 64'd7, 64'd0);
    read(4'h6, 4'h5, 4'hF);
    check("after_halt_r5", valA, 64'd0);
    check("after_halt_retired", {32'd0, retired}, 64'd5);

    do_reset();
    step("invalid", 1'b1, 4'hC, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0);
    check("invalid_flag", {63'd0, instr_err}, 64'd1);
    check("invalid_retired", {32'd0, retired}, 64'd0);
    step("after_err", 1'b1, 4'h3, 4'hF, 4'h6, 1'b0, 64'd9, 64'd0);

    // 6. async reset between edges, then commit coincident with reset
    do_reset();
    step("w_r2", 1'b1, 4'h3, 4'hF, 4'h2, 1'b0, 64'd9, 64'd0);
    read(4'h6, 4'h2, 4'hF);
    check("pre_async_r2", valA, 64'd9);
    #1;
    rst = 1'b1;
    #1;
    check("async_r2", valA, 64'd0);
    m_reset();
    wb_en = 1'b1; icode = 4'h3; rB = 4'h2; valE = 64'h55;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wb_en = 1'b0;
    check("rst_edge_retired", {32'd0, retired}, 64'd0);
    read(4'h6, 4'h2, 4'hF);
    check("rst_edge_r2", valA, 64'd0);

    // Randomized instruction stream
    for (int n = 0; n < 600; n++) begin
      logic [3:0] ic;
      int sel;
      sel = $urandom_range(0, 99);
      if (sel < 2)      ic = 4'h0;
      else if (sel < 4) ic = 4'(12 + $urandom_range(0, 3));
      else              ic = 4'($urandom_range(1, 11));
      step("rand", ($urandom_range(0, 9) != 0), ic, 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           {$urandom, $urandom}, {$urandom, $urandom});
      if ((m_halted || m_err) && $urandom_range(0, 3) == 0) do_reset();
    end

    // Full register sweep against the model
    for (int r = 0; r < 15; r++) begin
      read(4'h6, 4'(r), 4'(r));
      check("sweep_a", valA, m_read(4'(r)));
      check("sweep_b", valB, m_read(4'(r)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
